// File: rtl/multiply_unit.sv
// Iterative shift-add multiplier for MULU.W / MULS.W: one partial product per clock,
// sign applied once at the end from latched operand magnitudes.
module multiply_unit #(
  parameter int op_width = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    START,
  input  logic                    SIGNED,
  input  logic [op_width-1:0]     A,
  input  logic [op_width-1:0]     B,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [2*op_width-1:0]   RESULT,
  output logic                    FLAG_N,
  output logic                    FLAG_Z
);
  localparam int CW = $clog2(op_width + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE_S} state_t;

  state_t                  state, state_nxt;
  logic [op_width-1:0]     mcand, mplier;
  logic [op_width-1:0]     mag_a, mag_b;
  logic [2*op_width-1:0]   acc, prod;
  logic [op_width:0]       sum;
  logic [CW-1:0]           count;
  logic                    neg, last;

  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (SIGNED && A[op_width-1]) ? -A : A;
    mag_b = (SIGNED && B[op_width-1]) ? -B : B;
    sum   = {1'b0, acc[2*op_width-1:op_width]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod  = neg ? -acc : acc;
    last  = (count == CW'(op_width - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIX;
      FIX:     state_nxt = DONE_S;
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == RUN) || (state == FIX);
  assign DONE = (state == DONE_S);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      RESULT <= '0;
      FLAG_N <= 1'b0;
      FLAG_Z <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= SIGNED & (A[op_width-1] ^ B[op_width-1]);
          acc    <= '0;
          count  <= '0;
        end
        // Add carry lands in the MSB as the accumulator shifts right.
        RUN: begin
          acc    <= {sum, acc[op_width-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        FIX: begin
          RESULT <= prod;
          FLAG_N <= prod[2*op_width-1];
          FLAG_Z <= (prod == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiply_unit.sv
// Scoreboard bench for multiply_unit: driver pushes expected products, monitor
// pops and checks on every DONE pulse.
module tb_multiply_unit;
  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic          SIGNED = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          BUSY, DONE, FLAG_N, FLAG_Z;
  logic [2*W-1:0] RESULT;

  typedef struct {
    logic [2*W-1:0] res;
    int             e0;
    string          name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  multiply_unit #(.op_width(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(logic s, logic [W-1:0] a, logic [W-1:0] b);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_N && DONE) begin
      chk("done_width", prev_done, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE with result %0h, expected no DONE", RESULT);
      end else begin
        e = sb.pop_front();
        chk({e.name, " result"}, RESULT, e.res);
        chk({e.name, " flag_n"}, FLAG_N, e.res[2*W-1]);
        chk({e.name, " flag_z"}, FLAG_Z, (e.res == '0));
        chk({e.name, " latency"}, cyc - e.e0, W + 1);
      end
    end
    prev_done <= DONE;
  end

  task automatic run_op(logic s, logic [W-1:0] a, logic [W-1:0] b, string nm, bit hold);
    int n = 0;
    while ((BUSY || DONE) && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk({nm, " idle_timeout"}, BUSY, 1'b0);
    SIGNED = s; A = a; B = b; START = 1'b1;
    sb.push_back('{model(s, a, b), cyc + 1, nm});
    @(negedge CLK);
    chk({nm, " busy"}, BUSY, 1'b1);
    if (!hold) START = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      A = W'($urandom); B = W'($urandom); SIGNED = 1'($urandom);
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout: got no DONE in 40 cycles, expected DONE", nm);
      sb.delete();
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    logic [2*W-1:0] held;
    repeat (2) @(negedge CLK);
    chk("reset busy", BUSY, 1'b0);
    chk("reset done", DONE, 1'b0);
    chk("reset result", RESULT, '0);
    chk("reset flags", {FLAG_N, FLAG_Z}, 2'b00);
    RESET_N = 1'b1;
    @(negedge CLK);

    run_op(1'b0, 16'hFFFF, 16'hFFFF, "mulu_ffff_ffff", 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h0002, "muls_m1_2", 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0002, "mulu_ffff_2", 1'b0);
    run_op(1'b1, 16'h8000, 16'h8000, "muls_8000_8000", 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, "muls_8000_1", 1'b0);
    run_op(1'b0, 16'h1234, 16'h0000, "mulu_zero", 1'b0);
    run_op(1'b1, 16'h7FFF, 16'h7FFF, "muls_7fff_7fff", 1'b0);
    run_op(1'b1, 16'hABCD, 16'h1357, "hold_start", 1'b1);

    // Result must hold while idle with inputs moving and START low.
    held = RESULT;
    repeat (5) begin A = W'($urandom); B = W'($urandom); @(negedge CLK); end
    chk("result_hold", RESULT, held);
    chk("idle_busy", BUSY, 1'b0);

    // Abort mid-RUN with reset.
    SIGNED = 1'b0; A = 16'h1234; B = 16'h5678; START = 1'b1;
    sb.push_back('{model(1'b0, 16'h1234, 16'h5678), cyc + 1, "aborted"});
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    RESET_N = 1'b0;
    sb.delete();
    @(negedge CLK);
    chk("midrun_reset busy", BUSY, 1'b0);
    chk("midrun_reset done", DONE, 1'b0);
    chk("midrun_reset result", RESULT, '0);
    chk("midrun_reset flags", {FLAG_N, FLAG_Z}, 2'b00);
    RESET_N = 1'b1;
    @(negedge CLK);
    run_op(1'b0, 16'd3, 16'd5, "mulu_3_5", 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (i % 7 == 0) ra = 16'h8000;
      run_op(rs, ra, rb, $sformatf("rand%0d", i), 1'($urandom));
    end

    repeat (25) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
